// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner and its event FIFO.
// It holds the key-code width helper, the event record and the scan FSM encoding.
package keypad_pkg;

  localparam int CODE_MAX_W = 6;

  function automatic int key_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  typedef struct packed {
    logic                  is_release;
    logic [CODE_MAX_W-1:0] code;
  } key_event_t;

  typedef enum logic [0:0] {
    SCAN = 1'b0,
    EMIT = 1'b1
  } scan_state_e;

endpackage

// File: rtl/key_event_fifo.sv
// Small synchronous event FIFO that drops a push when full (unless a pop frees a slot the same cycle).
// The dropped output pulses for one cycle when an entry is discarded.
module key_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             dropped
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A pop on an empty FIFO is ignored, so push+pop while empty is a push only.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dropped = push && full && !do_pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column ring, row synchroniser, frame debounce and an
// emit walk that turns accepted matrix changes into press/release events.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = 3,
  parameter int COLS       = 3,
  parameter int CLK_DIV    = 5464,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int KEY_W      = key_width(ROWS, COLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ROWS-1:0]  row,
  output logic [COLS-1:0]  column,
  output logic [KEY_W-1:0] key,
  output logic             key_release,
  output logic             valid_key,
  input  logic             key_ready,
  output logic             overflow,
  output logic [0:0]       fsm_state
);

  localparam int N  = ROWS * COLS;
  localparam int PW = $clog2(CLK_DIV);
  localparam int CW = $clog2(COLS);
  localparam logic [0:0] ST_SCAN = SCAN;
  localparam logic [0:0] ST_EMIT = EMIT;

  logic [ROWS-1:0]  row_meta, row_sync, pressed;
  logic [PW-1:0]    presc;
  logic             tick, frame_end;
  logic [CW-1:0]    col_idx, next_col;
  logic [N-1:0]     snapshot, frame_now, prev_frame, accepted, emit_snap;
  logic [3:0]       stable_cnt, cnt_next;
  logic [0:0]       state;
  logic [KEY_W-1:0] idx;
  logic             start_emit, ev_push, last_idx;
  key_event_t       ev;
  logic [KEY_W:0]   head, held;
  logic             fifo_full, fifo_empty, fifo_dropped, pop;

  assign pressed  = ~row_sync;
  assign tick     = (presc == PW'(CLK_DIV - 1));
  assign next_col = (col_idx == CW'(COLS - 1)) ? '0 : col_idx + 1'b1;

  always_comb begin
    frame_now = snapshot;
    frame_now[(COLS-1)*ROWS +: ROWS] = pressed;
    frame_end = tick && (col_idx == CW'(COLS - 1));
    if (frame_now == prev_frame)
      cnt_next = (stable_cnt == 4'(DEBOUNCE)) ? stable_cnt : stable_cnt + 1'b1;
    else
      cnt_next = 4'd1;
    start_emit = frame_end && (state == ST_SCAN) &&
                 (cnt_next == 4'(DEBOUNCE)) && (frame_now != accepted);
    ev.is_release = ~emit_snap[idx];
    ev.code       = CODE_MAX_W'(idx);
    ev_push       = (state == ST_EMIT) && (emit_snap[idx] != accepted[idx]);
    last_idx      = (idx == KEY_W'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta   <= '1;
      row_sync   <= '1;
      presc      <= '0;
      col_idx    <= '0;
      column     <= ~COLS'(1);
      snapshot   <= '0;
      prev_frame <= '0;
      accepted   <= '0;
      emit_snap  <= '0;
      stable_cnt <= '0;
      state      <= ST_SCAN;
      idx        <= '0;
      overflow   <= 1'b0;
      held       <= '0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
      presc    <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        snapshot[col_idx*ROWS +: ROWS] <= pressed;
        col_idx <= next_col;
        column  <= ~(COLS'(1) << next_col);
      end
      if (frame_end) begin
        stable_cnt <= cnt_next;
        if (frame_now != prev_frame) prev_frame <= frame_now;
      end
      // Scanning keeps running while EMIT walks its own frozen copy of the frame.
      case (state)
        ST_SCAN: begin
          if (start_emit) begin
            state     <= ST_EMIT;
            idx       <= '0;
            emit_snap <= frame_now;
          end
        end
        default: begin
          if (ev_push) accepted[idx] <= emit_snap[idx];
          if (last_idx) state <= ST_SCAN;
          else          idx   <= idx + 1'b1;
        end
      endcase
      if (fifo_dropped) overflow <= 1'b1;
      if (valid_key)    held     <= head;
    end
  end

  // Handshake: an event transfers on any clk edge where valid_key && key_ready;
  // valid_key never depends on key_ready, and the head is stable until taken.
  assign valid_key = ~fifo_empty;
  assign pop       = valid_key && key_ready;
  assign {key_release, key} = valid_key ? head : held;
  assign fsm_state = state;

  key_event_fifo #(
    .WIDTH (KEY_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ev_push),
    .push_data ({ev.is_release, ev.code[KEY_W-1:0]}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .dropped   (fifo_dropped)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a 3x3 instance with a fast prescaler and a 4x2 instance.
// A key-matrix model drives the rows from the driven columns; handshakes are logged and checked.
module tb_keypad_scanner;

  localparam int FRAME_A = 3 * 16;
  localparam int FRAME_B = 2 * 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] pad_a;
  logic [7:0] pad_b;
  logic [2:0] row_a, column_a;
  logic [3:0] row_b;
  logic [1:0] column_b;
  logic [3:0] key_a;
  logic [2:0] key_b;
  logic       rel_a, rel_b, valid_a, valid_b, ready_a, ready_b, ovf_a, ovf_b;
  logic [0:0] state_a, state_b;

  int checks = 0;
  int failures = 0;
  int sb_a = 0;
  int valid_cycles_a = 0;
  int v0;
  logic [4:0] got_a[$];
  logic [4:0] exp_a[$];
  logic [3:0] got_b[$];

  always #5 clk = ~clk;

  keypad_scanner #(.ROWS(3), .COLS(3), .CLK_DIV(16), .DEBOUNCE(4), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .row(row_a), .column(column_a), .key(key_a),
    .key_release(rel_a), .valid_key(valid_a), .key_ready(ready_a),
    .overflow(ovf_a), .fsm_state(state_a));

  keypad_scanner #(.ROWS(4), .COLS(2), .CLK_DIV(10), .DEBOUNCE(4), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .row(row_b), .column(column_b), .key(key_b),
    .key_release(rel_b), .valid_key(valid_b), .key_ready(ready_b),
    .overflow(ovf_b), .fsm_state(state_b));

  // Keypad model: a held key pulls its row low while its column is driven low.
  always_comb begin
    row_a = '1;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        if (pad_a[c*3+r] && !column_a[c]) row_a[r] = 1'b0;
    row_b = '1;
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 4; r++)
        if (pad_b[c*4+r] && !column_b[c]) row_b[r] = 1'b0;
  end

  always @(posedge clk) begin
    if (!reset && valid_a && ready_a) got_a.push_back({rel_a, key_a});
    if (!reset && valid_b && ready_b) got_b.push_back({rel_b, key_b});
    if (!reset && valid_a) valid_cycles_a++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames_a(input int n);
    repeat (n * FRAME_A) @(negedge clk);
  endtask

  task automatic check_events_a(input string tag);
    chk({tag, "_count"}, 32'(got_a.size()), 32'(exp_a.size()));
    for (int i = sb_a; i < exp_a.size() && i < got_a.size(); i++)
      chk(tag, 32'(got_a[i]), 32'(exp_a[i]));
    sb_a = exp_a.size();
  endtask

  // Lands just after the column ring returns to column 0, so a new pad pattern
  // is sampled entirely within one frame.
  task automatic align_a(input string tag);
    int n = 0;
    while (column_a !== 3'b011 && n < 200) begin @(negedge clk); n++; end
    while (column_a !== 3'b110 && n < 200) begin @(negedge clk); n++; end
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  initial begin
    reset   = 1'b1;
    pad_a   = '0;
    pad_b   = '0;
    ready_a = 1'b0;
    ready_b = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_column_a", 32'(column_a), 32'h6);
    chk("rst_valid_a", 32'(valid_a), 32'd0);
    chk("rst_ovf_a", 32'(ovf_a), 32'd0);
    chk("rst_key_a", 32'({rel_a, key_a}), 32'd0);
    chk("rst_state_a", 32'(state_a), 32'd0);
    chk("rst_column_b", 32'(column_b), 32'h2);
    reset = 1'b0;

    // 4x2 column ring: 10 cycles on column 0, then 10 on column 1.
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k % 10 == 5) chk("col_seq_b", 32'(column_b), ((k / 10) % 2 == 0) ? 32'h2 : 32'h1);
    end

    // Row 3, column 1 of the 4x2 pad is code 1*4+3 = 7.
    ready_b  = 1'b1;
    pad_b[7] = 1'b1;
    repeat (7 * FRAME_B) @(negedge clk);
    chk("b_press_count", 32'(got_b.size()), 32'd1);
    if (got_b.size() > 0) chk("b_press_ev", 32'(got_b[0]), 32'h7);

    // Key 7 of the 3x3 pad: row 1 with column 2 low.
    ready_a  = 1'b1;
    v0       = valid_cycles_a;
    pad_a[7] = 1'b1;
    wait_frames_a(2);
    chk("press7_early", 32'(valid_cycles_a - v0), 32'd0);
    wait_frames_a(5);
    exp_a.push_back({1'b0, 4'd7});
    check_events_a("press7");
    pad_a[7] = 1'b0;
    wait_frames_a(7);
    exp_a.push_back({1'b1, 4'd7});
    check_events_a("release7");

    // Two-frame bounce on key 4 never reaches the debounce threshold.
    v0       = valid_cycles_a;
    pad_a[4] = 1'b1;
    wait_frames_a(2);
    pad_a[4] = 1'b0;
    wait_frames_a(8);
    chk("bounce_valid", 32'(valid_cycles_a - v0), 32'd0);
    check_events_a("bounce");

    // Keys 0 and 8 in the same frame, held in the FIFO and popped one at a time.
    ready_a = 1'b0;
    align_a("align_08");
    pad_a[0] = 1'b1;
    pad_a[8] = 1'b1;
    wait_frames_a(7);
    chk("dual_valid", 32'(valid_a), 32'd1);
    chk("dual_head0", 32'({rel_a, key_a}), 32'h00);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    chk("dual_head8", 32'({rel_a, key_a}), 32'h08);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    chk("dual_empty", 32'(valid_a), 32'd0);
    exp_a.push_back({1'b0, 4'd0});
    exp_a.push_back({1'b0, 4'd8});
    check_events_a("dual_press");
    ready_a = 1'b1;
    align_a("align_08r");
    pad_a[0] = 1'b0;
    pad_a[8] = 1'b0;
    wait_frames_a(7);
    exp_a.push_back({1'b1, 4'd0});
    exp_a.push_back({1'b1, 4'd8});
    check_events_a("dual_release");

    // Six presses into a four-entry FIFO with the consumer stalled.
    ready_a = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      pad_a[k] = 1'b1;
      wait_frames_a(7);
      if (k == 4) chk("full_no_ovf", 32'(ovf_a), 32'd0);
    end
    chk("ovf_set", 32'(ovf_a), 32'd1);
    chk("ovf_head", 32'({rel_a, key_a}), 32'h01);
    ready_a = 1'b1;
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 4; k++) exp_a.push_back(5'(k));
    check_events_a("ovf_drain");
    chk("ovf_sticky", 32'(ovf_a), 32'd1);
    chk("ovf_empty", 32'(valid_a), 32'd0);

    // Reset in the middle of an emit walk with events queued.
    ready_a = 1'b0;
    align_a("align_rst");
    pad_a = '0;
    begin
      int n = 0;
      while (state_a !== 1'b1 && n < 8 * FRAME_A) begin @(negedge clk); n++; end
      chk("emit_reached", 32'(n < 8 * FRAME_A), 32'd1);
    end
    repeat (4) @(negedge clk);
    chk("pre_rst_valid", 32'(valid_a), 32'd1);
    chk("pre_rst_state", 32'(state_a), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(valid_a), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_a), 32'd0);
    chk("mid_rst_column", 32'(column_a), 32'h6);
    chk("mid_rst_state", 32'(state_a), 32'd0);
    reset = 1'b0;
    v0 = valid_cycles_a;
    wait_frames_a(7);
    chk("post_rst_quiet", 32'(valid_cycles_a - v0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
